// File: rtl/axi_stream_to_bt656.sv
// axi_stream_to_bt656: BT.656 transmitter fed by an AXI4-Stream YCbCr 4:2:2 pixel stream.
// Ports: axi_clk_i/axi_rst_i byte clock and sync active-high reset; tx_en_i enables transmission;
// s_t*_i/s_tready_o AXI-S slave (tdata [7:0]=Y, [15:8]=C); bt656_data_o registered BT.656 byte;
// locked_o stream aligned; underrun_o/sync_err_o one-cycle error pulses.
module axi_stream_to_bt656 #(
  parameter int H_ACTIVE    = 720,
  parameter int H_BLANK     = 268,
  parameter int V_BLANK_TOP = 20,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK_BOT = 25
) (
  input  logic        axi_clk_i,
  input  logic        axi_rst_i,
  input  logic        tx_en_i,
  input  logic [15:0] s_tdata_i,
  input  logic        s_tvalid_i,
  input  logic        s_tuser_i,
  input  logic        s_tlast_i,
  output logic        s_tready_o,
  output logic [7:0]  bt656_data_o,
  output logic        locked_o,
  output logic        underrun_o,
  output logic        sync_err_o
);
  localparam int H_TOTAL = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int V_TOTAL = V_BLANK_TOP + V_ACTIVE + V_BLANK_BOT;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_END    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_EAV    = HW'(4);
  localparam logic [HW-1:0] H_SAV    = HW'(4 + H_BLANK);
  localparam logic [HW-1:0] H_ACT    = HW'(8 + H_BLANK);
  localparam logic [HW-1:0] PIX_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_END    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FIRST  = VW'(V_BLANK_TOP);
  localparam logic [VW-1:0] V_LAST   = VW'(V_BLANK_TOP + V_ACTIVE - 1);
  typedef enum logic [1:0] {ALIGN, WAIT_FRAME, RUN} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] h_q, h_d, k, t, pix;
  logic [VW-1:0] v_q, v_d;
  logic [7:0] y_q, y_d, data_q, data_d, xy, code;
  logic under_q, under_d, serr_q, serr_d;
  logic v_act, h_act, hb, vb, due, first, last, ok;
  logic [1:0] idx;
  function automatic logic [7:0] clamp(input logic [7:0] d);
    return d == 8'h00 ? 8'h01 : d == 8'hFF ? 8'hFE : d;
  endfunction
  always_comb begin
    h_d = h_q == H_END ? '0 : h_q + 1'b1;
    v_d = h_q != H_END ? v_q : v_q == V_END ? '0 : v_q + 1'b1;
    v_act = v_q >= V_FIRST && v_q <= V_LAST;
    h_act = h_q >= H_ACT;
    hb = h_q < H_EAV;
    vb = ~v_act;
    k = h_q - H_ACT;
    t = h_q - H_SAV;
    pix = {1'b0, k[HW-1:1]};
    due = state_q == RUN && tx_en_i && v_act && h_act && ~k[0];
    first = v_q == V_FIRST && pix == '0;
    last = pix == PIX_LAST;
    under_d = due && ~s_tvalid_i;
    // Sideband is checked even without tvalid so a bad marker on an underrun cycle is still flagged.
    serr_d = due && (s_tuser_i != first || s_tlast_i != last);
    ok = due && s_tvalid_i && ~serr_d;
    // Y is reloaded on every even active byte, with black when no pixel is delivered.
    y_d = h_act && ~k[0] ? (ok ? clamp(s_tdata_i[7:0]) : 8'h10) : y_q;
    xy = {1'b1, 1'b0, vb, hb, vb ^ hb, hb, vb, vb ^ hb};
    idx = hb ? h_q[1:0] : t[1:0];
    code = idx == 2'd0 ? 8'hFF : idx == 2'd3 ? xy : 8'h00;
    data_d = hb ? code :
             h_q < H_SAV ? (h_q[0] ? 8'h10 : 8'h80) :
             ~h_act ? code :
             ~v_act ? (k[0] ? 8'h10 : 8'h80) :
             k[0] ? y_q :
             ok ? clamp(s_tdata_i[15:8]) : 8'h80;
    state_d = ~tx_en_i ? ALIGN :
              state_q == ALIGN ? (s_tvalid_i && s_tuser_i ? WAIT_FRAME : ALIGN) :
              state_q == WAIT_FRAME ? (h_q == '0 && v_q == V_FIRST ? RUN : WAIT_FRAME) :
              under_d || serr_d ? ALIGN :
              h_q == H_END && v_q == V_LAST ? WAIT_FRAME : RUN;
  end
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state_q <= ALIGN;
      h_q     <= '0;
      v_q     <= '0;
      y_q     <= 8'h10;
      data_q  <= 8'h10;
      under_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      y_q     <= y_d;
      data_q  <= data_d;
      under_q <= under_d;
      serr_q  <= serr_d;
    end
  end
  assign s_tready_o = ~axi_rst_i && tx_en_i &&
                      (state_q == ALIGN ? ~(s_tvalid_i && s_tuser_i) : due);
  assign bt656_data_o = data_q;
  assign locked_o = state_q == WAIT_FRAME || state_q == RUN;
  assign underrun_o = under_q;
  assign sync_err_o = serr_q;
endmodule

// File: tb/tb_axi_stream_to_bt656.sv
// tb_axi_stream_to_bt656: directed bench for the BT.656 transmitter with a 4/4/1/2/1 timing.
module tb_axi_stream_to_bt656;
  logic clk = 1'b0;
  logic rst, tx_en, s_tvalid, s_tuser, s_tlast, s_tready, locked, underrun, sync_err;
  logic [15:0] s_tdata;
  logic [7:0] data;
  int nchk = 0, npass = 0;
  int c = 0, b = 0, gap_c = -1;
  bit src_on = 0;
  logic [7:0] cap [0:399];
  bit rdy [0:399];
  bit und [0:399];
  bit se [0:399];
  bit lk [0:399];
  always #5 clk = ~clk;
  axi_stream_to_bt656 #(.H_ACTIVE(4), .H_BLANK(4), .V_BLANK_TOP(1), .V_ACTIVE(2), .V_BLANK_BOT(1)) dut (
    .axi_clk_i(clk), .axi_rst_i(rst), .tx_en_i(tx_en), .s_tdata_i(s_tdata),
    .s_tvalid_i(s_tvalid), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
    .bt656_data_o(data), .locked_o(locked), .underrun_o(underrun), .sync_err_o(sync_err));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) $display("FAIL %s got %0h expected %0h", tag, got, exp);
    else npass++;
  endtask
  task automatic set_src();
    int p;
    p = b % 8;
    s_tvalid = src_on && c != gap_c;
    s_tdata = b == 33 ? 16'h00FF : {8'h40 + 8'(p), 8'(p)};
    s_tuser = p == 0;
    s_tlast = p % 4 == 3 || b == 26;
  endtask
  task automatic step();
    bit hs;
    set_src();
    #1;
    rdy[c] = s_tready;
    hs = s_tready && s_tvalid;
    @(posedge clk);
    #1;
    if (hs) b++;
    cap[c] = data;
    und[c] = underrun;
    se[c] = sync_err;
    lk[c] = locked;
    c++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tuser = 1'b0;
    s_tlast = 1'b0;
    s_tdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] line0 [0:19];
    int bad;
    line0 = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
              8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10};
    tx_en = 1'b1;
    do_reset();
    check("rst_data", data, 8'h10);
    check("rst_tready", s_tready, 0);
    check("rst_locked", locked, 0);
    check("rst_underrun", underrun, 0);
    check("rst_sync_err", sync_err, 0);
    rst = 1'b0;
    c = 0;
    src_on = 0;
    repeat (40) step();
    for (int i = 0; i < 20; i++) check($sformatf("line0_%0d", i), cap[i], line0[i]);
    check("line1_eav_xy", cap[23], 8'h9D);
    check("line1_sav_xy", cap[31], 8'h80);
    check("idle_active_c", cap[32], 8'h80);
    check("idle_active_y", cap[33], 8'h10);
    check("idle_locked", lk[39], 0);
    do_reset();
    rst = 1'b0;
    c = 0;
    b = 0;
    gap_c = 116;
    src_on = 1;
    repeat (374) step();
    check("sof_held_tready", rdy[0], 0);
    check("wait_locked", lk[0], 1);
    check("f0_c0", cap[32], 8'h40);
    check("f0_y0_clamp", cap[33], 8'h01);
    check("f0_c1", cap[34], 8'h41);
    check("f0_y1", cap[35], 8'h01);
    check("f0_y3", cap[39], 8'h03);
    check("f0_c4", cap[52], 8'h44);
    check("f0_y7", cap[59], 8'h07);
    check("tready_even", rdy[32], 1);
    check("tready_odd", rdy[33], 0);
    check("vbot_eav_xy", cap[63], 8'hB6);
    check("f1_c0", cap[112], 8'h40);
    check("f1_y1", cap[115], 8'h01);
    check("underrun_pulse", und[116], 1);
    check("underrun_quiet", und[115], 0);
    check("underrun_no_serr", se[116], 0);
    check("underrun_c_black", cap[116], 8'h80);
    check("underrun_y_black", cap[117], 8'h10);
    check("underrun_pulse_len", und[117], 0);
    check("underrun_unlocked", lk[116], 0);
    check("align_discard_tready", rdy[117], 1);
    check("f1_line2_black", cap[132], 8'h80);
    check("f1_line2_black_y", cap[133], 8'h10);
    check("relock_locked", lk[200], 1);
    check("f2_c0", cap[192], 8'h40);
    check("f2_y0", cap[193], 8'h01);
    check("f3_c1", cap[274], 8'h41);
    check("sync_err_pulse", se[276], 1);
    check("sync_err_no_under", und[276], 0);
    check("sync_err_black_c", cap[276], 8'h80);
    check("sync_err_black_y", cap[277], 8'h10);
    check("sync_err_unlocked", lk[277], 0);
    check("f3_line2_black", cap[292], 8'h80);
    check("f4_c0", cap[352], 8'h40);
    check("clamp_c_00", cap[354], 8'h01);
    check("clamp_y_ff", cap[355], 8'hFE);
    check("f4_y3", cap[359], 8'h03);
    check("f4_locked", lk[373], 1);
    bad = 0;
    for (int i = 0; i < 374; i++)
      if (i % 20 >= 12 && (i / 20) % 4 >= 1 && (i / 20) % 4 <= 2 && (cap[i] == 8'h00 || cap[i] == 8'hFF)) bad++;
    check("no_reserved_active", bad, 0);
    rst = 1'b1;
    src_on = 0;
    step();
    check("midrst_data", data, 8'h10);
    check("midrst_tready", s_tready, 0);
    check("midrst_locked", locked, 0);
    rst = 1'b0;
    c = 0;
    repeat (4) step();
    check("post_rst_eav0", cap[0], 8'hFF);
    check("post_rst_eav1", cap[1], 8'h00);
    check("post_rst_eav2", cap[2], 8'h00);
    check("post_rst_eav3", cap[3], 8'hB6);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
